// File: rtl/id_ex_control_pkg.sv
// rtl/id_ex_control_pkg.sv - shared opcodes, funct codes, ALU ops and control word
package id_ex_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;

  localparam logic [5:0] F_ADD = 6'd32;
  localparam logic [5:0] F_SUB = 6'd34;
  localparam logic [5:0] F_AND = 6'd36;
  localparam logic [5:0] F_OR  = 6'd37;
  localparam logic [5:0] F_SLT = 6'd42;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       branch;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_NOP = '0;

  // R-type instructions are only legal for the five ALU functions EX implements
  function automatic logic funct_supported(input logic [5:0] funct);
    return (funct == F_ADD) || (funct == F_SUB) || (funct == F_AND) ||
           (funct == F_OR)  || (funct == F_SLT);
  endfunction

endpackage

// File: rtl/id_ex_control_main_decode.sv
// rtl/id_ex_control_main_decode.sv - combinational main control decoder
module main_decode
  import id_ex_control_pkg::*;
(
  input  logic       in_valid,
  input  logic [5:0] in_opcode,
  input  logic [5:0] in_funct,
  output ctrl_word_t ctrl,
  output logic       illegal
);

  // Map the opcode to its control word; anything unrecognised is flagged illegal
  always_comb begin
    ctrl    = CTRL_NOP;
    illegal = 1'b0;
    case (in_opcode)
      OP_RTYPE: begin
        ctrl.alu_op    = ALUOP_FUNCT;
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        illegal        = in_valid && !funct_supported(in_funct);
      end
      OP_LW: begin
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      OP_BEQ: begin
        ctrl.alu_op = ALUOP_SUB;
        ctrl.branch = 1'b1;
      end
      OP_ADDI: begin
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      default: begin
        illegal = in_valid;
      end
    endcase
  end

endmodule

// File: rtl/id_ex_control.sv
// rtl/id_ex_control.sv - ID/EX control pipeline register with hazard handling
module id_ex_control
  import id_ex_control_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [5:0]       in_opcode,
  input  logic [5:0]       in_funct,
  input  logic             bubble,
  input  logic             hold,
  input  logic             flush,
  output logic [1:0]       ctrl_alu_op_id_ex,
  output logic [5:0]       ctrl_funct_id_ex,
  output logic             ctrl_reg_dst_id_ex,
  output logic             ctrl_alu_src_id_ex,
  output logic             ctrl_mem_read_id_ex,
  output logic             ctrl_mem_write_id_ex,
  output logic             ctrl_mem_to_reg_id_ex,
  output logic             ctrl_reg_write_id_ex,
  output logic             ctrl_branch_id_ex,
  output logic             ctrl_valid_id_ex,
  output logic             ctrl_illegal_id_ex,
  output logic [CNT_W-1:0] illegal_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  ctrl_word_t       dec_ctrl;
  logic             dec_illegal;

  ctrl_word_t       ctrl_q;
  logic [5:0]       funct_q;
  logic             valid_q;
  logic             illegal_q;
  logic [CNT_W-1:0] count_q;

  main_decode u_main_decode (
    .in_valid  (in_valid),
    .in_opcode (in_opcode),
    .in_funct  (in_funct),
    .ctrl      (dec_ctrl),
    .illegal   (dec_illegal)
  );

  // ID/EX register: reset > flush > hold > bubble > normal load; counter only moves on a real illegal load
  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl_q    <= CTRL_NOP;
      funct_q   <= 6'd0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else if (flush) begin
      ctrl_q    <= CTRL_NOP;
      funct_q   <= 6'd0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else if (hold) begin
      ctrl_q    <= ctrl_q;
      funct_q   <= funct_q;
      valid_q   <= valid_q;
      illegal_q <= illegal_q;
    end else if (bubble || !in_valid) begin
      ctrl_q    <= CTRL_NOP;
      funct_q   <= 6'd0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else if (dec_illegal) begin
      ctrl_q    <= CTRL_NOP;
      funct_q   <= 6'd0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b1;
      if (count_q != CNT_MAX) begin
        count_q <= count_q + CNT_ONE;
      end
    end else begin
      ctrl_q    <= dec_ctrl;
      funct_q   <= in_funct;
      valid_q   <= 1'b1;
      illegal_q <= 1'b0;
    end
  end

  assign ctrl_alu_op_id_ex     = ctrl_q.alu_op;
  assign ctrl_funct_id_ex      = funct_q;
  assign ctrl_reg_dst_id_ex    = ctrl_q.reg_dst;
  assign ctrl_alu_src_id_ex    = ctrl_q.alu_src;
  assign ctrl_mem_read_id_ex   = ctrl_q.mem_read;
  assign ctrl_mem_write_id_ex  = ctrl_q.mem_write;
  assign ctrl_mem_to_reg_id_ex = ctrl_q.mem_to_reg;
  assign ctrl_reg_write_id_ex  = ctrl_q.reg_write;
  assign ctrl_branch_id_ex     = ctrl_q.branch;
  assign ctrl_valid_id_ex      = valid_q;
  assign ctrl_illegal_id_ex    = illegal_q;
  assign illegal_count         = count_q;

endmodule

// File: tb/tb_id_ex_control.sv
// tb/tb_id_ex_control.sv - scoreboard bench for id_ex_control
module tb_id_ex_control;

  localparam int CNT_W = 2;

  typedef struct packed {
    logic [1:0] alu_op;
    logic [5:0] funct;
    logic [6:0] bits;   // reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write, branch
    logic       valid;
    logic       illegal;
    logic [CNT_W-1:0] count;
  } obs_t;

  logic             clock;
  logic             reset;
  logic             in_valid;
  logic [5:0]       in_opcode;
  logic [5:0]       in_funct;
  logic             bubble;
  logic             hold;
  logic             flush;
  logic [1:0]       ctrl_alu_op_id_ex;
  logic [5:0]       ctrl_funct_id_ex;
  logic             ctrl_reg_dst_id_ex;
  logic             ctrl_alu_src_id_ex;
  logic             ctrl_mem_read_id_ex;
  logic             ctrl_mem_write_id_ex;
  logic             ctrl_mem_to_reg_id_ex;
  logic             ctrl_reg_write_id_ex;
  logic             ctrl_branch_id_ex;
  logic             ctrl_valid_id_ex;
  logic             ctrl_illegal_id_ex;
  logic [CNT_W-1:0] illegal_count;

  id_ex_control #(.CNT_W(CNT_W)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .in_valid              (in_valid),
    .in_opcode             (in_opcode),
    .in_funct              (in_funct),
    .bubble                (bubble),
    .hold                  (hold),
    .flush                 (flush),
    .ctrl_alu_op_id_ex     (ctrl_alu_op_id_ex),
    .ctrl_funct_id_ex      (ctrl_funct_id_ex),
    .ctrl_reg_dst_id_ex    (ctrl_reg_dst_id_ex),
    .ctrl_alu_src_id_ex    (ctrl_alu_src_id_ex),
    .ctrl_mem_read_id_ex   (ctrl_mem_read_id_ex),
    .ctrl_mem_write_id_ex  (ctrl_mem_write_id_ex),
    .ctrl_mem_to_reg_id_ex (ctrl_mem_to_reg_id_ex),
    .ctrl_reg_write_id_ex  (ctrl_reg_write_id_ex),
    .ctrl_branch_id_ex     (ctrl_branch_id_ex),
    .ctrl_valid_id_ex      (ctrl_valid_id_ex),
    .ctrl_illegal_id_ex    (ctrl_illegal_id_ex),
    .illegal_count         (illegal_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int   total = 0;
  int   bad   = 0;
  obs_t exp_q[$];
  obs_t model;          // what ID/EX should hold after the next edge
  bit   stim_done = 0;

  // Reference: what each opcode means, written as the instruction-set table
  function automatic bit ref_legal(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'd0) return fn inside {6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
    return op inside {6'd35, 6'd43, 6'd4, 6'd8};
  endfunction

  function automatic logic [8:0] ref_word(input logic [5:0] op);
    // {alu_op, reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write, branch}
    case (op)
      6'd0:    return {2'd2, 7'b1000010};
      6'd35:   return {2'd0, 7'b0110110};
      6'd43:   return {2'd0, 7'b0101000};
      6'd4:    return {2'd1, 7'b0000001};
      6'd8:    return {2'd0, 7'b0100010};
      default: return 9'd0;
    endcase
  endfunction

  function automatic obs_t nop_with(input logic [CNT_W-1:0] cnt, input logic ill);
    obs_t o;
    o = '0;
    o.illegal = ill;
    o.count = cnt;
    return o;
  endfunction

  task automatic step(input logic v, input logic [5:0] op, input logic [5:0] fn,
                      input logic bub, input logic hld, input logic fl, input logic rst);
    logic [8:0] w;
    reset = rst; in_valid = v; in_opcode = op; in_funct = fn;
    bubble = bub; hold = hld; flush = fl;
    if (rst)                     model = '0;
    else if (fl)                 model = nop_with(model.count, 1'b0);
    else if (hld)                model = model;
    else if (bub || !v)          model = nop_with(model.count, 1'b0);
    else if (!ref_legal(op, fn)) begin
      int c;
      c = int'(model.count) + 1;
      if (c > (1 << CNT_W) - 1) c = (1 << CNT_W) - 1;
      model = nop_with(CNT_W'(c), 1'b1);
    end else begin
      w = ref_word(op);
      model.alu_op  = w[8:7];
      model.bits    = w[6:0];
      model.funct   = fn;
      model.valid   = 1'b1;
      model.illegal = 1'b0;
    end
    exp_q.push_back(model);
    @(posedge clock);
    #2;
  endtask

  task automatic check_field(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // Monitor: after every edge, pop the expected ID/EX contents and compare
  initial begin
    obs_t e;
    forever begin
      @(posedge clock);
      #1;
      if (stim_done) break;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL queue_underflow at %0t: got 0 entries expected 1", $time);
      end else begin
        e = exp_q.pop_front();
        check_field("alu_op", int'(ctrl_alu_op_id_ex), int'(e.alu_op));
        check_field("funct", int'(ctrl_funct_id_ex), int'(e.funct));
        check_field("ctrl_bits", int'({ctrl_reg_dst_id_ex, ctrl_alu_src_id_ex, ctrl_mem_read_id_ex,
                                       ctrl_mem_write_id_ex, ctrl_mem_to_reg_id_ex,
                                       ctrl_reg_write_id_ex, ctrl_branch_id_ex}), int'(e.bits));
        check_field("valid", int'(ctrl_valid_id_ex), int'(e.valid));
        check_field("illegal", int'(ctrl_illegal_id_ex), int'(e.illegal));
        check_field("count", int'(illegal_count), int'(e.count));
      end
    end
  end

  // Stimulus: directed test-plan sequence, then randomized traffic
  initial begin
    logic [5:0] legal_ops [5] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd8};
    logic [5:0] legal_fn  [5] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
    model = '0;
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    // lw
    step(1, 35, 6'd5, 0, 0, 0, 0);
    // R-type slt then beq
    step(1, 0, 42, 0, 0, 0, 0);
    step(1, 4, 6'd9, 0, 0, 0, 0);
    // addi then hold three cycles with sw on the inputs
    step(1, 8, 6'd1, 0, 0, 0, 0);
    step(1, 43, 6'd2, 0, 1, 0, 0);
    step(1, 43, 6'd2, 1, 1, 0, 0);
    step(1, 43, 6'd2, 0, 1, 0, 0);
    step(1, 43, 6'd2, 0, 0, 0, 0);
    // bubble, then the same R-type, then flush+hold
    step(1, 0, 32, 1, 0, 0, 0);
    step(1, 0, 32, 0, 0, 0, 0);
    step(1, 43, 6'd3, 0, 1, 1, 0);
    // illegal opcode, illegal funct, then saturation
    step(1, 63, 6'd0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0);
    step(1, 17, 6'd0, 0, 0, 0, 0);
    step(1, 0, 33, 0, 0, 0, 0);
    step(1, 2, 6'd0, 0, 0, 0, 0);
    // illegal under flush / hold / bubble, and invalid illegal encoding
    step(1, 63, 6'd0, 0, 0, 1, 0);
    step(1, 8, 6'd4, 0, 0, 0, 0);
    step(1, 63, 6'd0, 0, 1, 0, 0);
    step(1, 63, 6'd0, 1, 0, 0, 0);
    step(0, 63, 6'd0, 0, 0, 0, 0);
    // reset mid-stream, then first live load right after
    step(1, 35, 6'd0, 0, 0, 0, 1);
    step(1, 63, 6'd0, 0, 0, 0, 0);
    step(1, 35, 6'd7, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] op, fn;
      op = ($urandom_range(0, 9) < 5) ? legal_ops[$urandom_range(0, 4)] : 6'($urandom);
      fn = ($urandom_range(0, 1) == 0) ? legal_fn[$urandom_range(0, 4)] : 6'($urandom);
      step(1'($urandom_range(0, 3) != 0), op, fn,
           1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 4) == 0),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 63) == 0));
    end
    stim_done = 1;
    @(posedge clock);
    #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_control.md
Name: id_ex_control

Overview:
- Producer side of the ALU-op interface: decodes the ID-stage opcode/funct into the main control word, including the 2-bit ALU op.
- Registers that word into the ID/EX pipeline register, so EX-stage logic sees ctrl_alu_op_id_ex and ctrl_funct_id_ex one cycle later.
- Handles hazard-unit bubbles, EX-stage holds and branch flushes.
- Keeps a saturating count of illegal instructions for debug.

Parameters:
- CNT_W, 8, width of the illegal-instruction counter.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  IF/ID holds a real instruction
- in_opcode  in  6  instruction[31:26]
- in_funct  in  6  instruction[5:0]
- bubble  in  1  load-use hazard: insert NOP into ID/EX
- hold  in  1  EX stall: freeze ID/EX contents
- flush  in  1  taken branch: kill the instruction entering ID/EX
- ctrl_alu_op_id_ex  out  2  ALU op: 0 add, 1 sub, 2 use funct
- ctrl_funct_id_ex  out  6  registered funct
- ctrl_reg_dst_id_ex, ctrl_alu_src_id_ex, ctrl_mem_read_id_ex, ctrl_mem_write_id_ex, ctrl_mem_to_reg_id_ex, ctrl_reg_write_id_ex, ctrl_branch_id_ex  out  1 each  registered control bits
- ctrl_valid_id_ex  out  1  ID/EX holds a live instruction
- ctrl_illegal_id_ex  out  1  the instruction killed in this slot was illegal (one-cycle pulse per load)
- illegal_count  out  CNT_W  saturating count of illegal instructions

Behaviour:
- Decode (combinational), giving alu_op, then the set bits:
  - opcode 0 (R-type): alu_op 2; reg_dst, reg_write.
  - 35 (lw): alu_op 0; alu_src, mem_read, mem_to_reg, reg_write.
  - 43 (sw): alu_op 0; alu_src, mem_write.
  - 4 (beq): alu_op 1; branch.
  - 8 (addi): alu_op 0; alu_src, reg_write.
- Unlisted control bits are 0.
- Illegal = in_valid AND (opcode not listed, OR opcode 0 with funct not in {32,34,36,37,42}).
- An illegal instruction loads as a NOP: all control bits 0, alu_op 0, valid 0, ctrl_illegal_id_ex 1.
- Register update priority, each clock edge:
  1. reset: all outputs 0, illegal_count 0.
  2. flush: NOP loaded (all 0, illegal 0); flush wins even if hold is also high.
  3. hold: all ID/EX outputs keep their values; ctrl_illegal_id_ex also holds.
  4. bubble: NOP loaded.
  5. Otherwise, in_valid=0 loads a NOP; in_valid=1 loads the decoded word, ctrl_funct_id_ex <= in_funct, valid <= NOT illegal.
- ctrl_funct_id_ex is 0 in every NOP case.
- Latency: exactly 1 cycle from ID inputs to ID/EX outputs; no combinational path from inputs to outputs.
- illegal_count increments by 1 only on a cycle that actually loads an illegal instruction (not under reset, flush, hold or bubble). It saturates at 2^CNT_W-1 and never wraps.
- Reset asserted mid-stream clears everything on that edge. The first live load can occur on the edge after reset deasserts.
- With hold=1 and bubble=1 together, hold wins and the held instruction is not lost.

Decomposition:
- Shared package holds:
  - opcode constants OP_RTYPE=0, OP_LW=35, OP_SW=43, OP_BEQ=4, OP_ADDI=8;
  - funct constants F_ADD=32, F_SUB=34, F_AND=36, F_OR=37, F_SLT=42;
  - ALU-op constants ALUOP_ADD=0, ALUOP_SUB=1, ALUOP_FUNCT=2;
  - a control-word struct typedef.
- One combinational sub-module, main_decode: opcode/funct/in_valid in, control word plus illegal flag out. id_ex_control instantiates it and adds the register, priority logic and counter.

Test Plan:
- Reset, then lw (opcode 35) with in_valid=1 -> next cycle alu_op=0, alu_src=1, mem_read=1, mem_to_reg=1, reg_write=1, valid=1.
- R-type funct 42, then beq -> cycle 1: alu_op=2, funct=42, reg_dst=1, reg_write=1; cycle 2: alu_op=1, branch=1, reg_write=0.
- Load addi, then assert hold 3 cycles while driving sw -> addi word stays stable 3 cycles; sw appears the cycle after hold drops.
- Drive R-type with bubble=1 for one cycle -> NOP (valid=0, all controls 0); next cycle without bubble loads the R-type. flush=1 with hold=1 -> NOP loaded.
- Opcode 63, then R-type funct 0 -> each gives ctrl_illegal_id_ex=1 and valid=0; illegal_count goes 0→1→2. With CNT_W=2, 5 illegal instructions -> count saturates at 3.
- Illegal instruction presented under flush or hold -> illegal_count unchanged. Reset mid-stream -> all outputs and count return to 0 on that edge.
